// File: rtl/ex_pkg.sv
// Shared encodings for the RV64 execute stage: ALUOp classes, ALU function codes,
// branch funct3 codes and the multiplier FSM states.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_MUL    = 2'b11;

  // {instr[30], funct3}
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b1000;
  localparam logic [3:0] FN_AND = 4'b0111;
  localparam logic [3:0] FN_OR  = 4'b0110;
  localparam logic [3:0] FN_XOR = 4'b0100;
  localparam logic [3:0] FN_SLL = 4'b0001;
  localparam logic [3:0] FN_SRL = 4'b0101;
  localparam logic [3:0] FN_SRA = 4'b1101;

  localparam logic [2:0] FN3_MUL = 3'b000;

  localparam logic [2:0] BR_BEQ = 3'b000;
  localparam logic [2:0] BR_BNE = 3'b001;
  localparam logic [2:0] BR_BLT = 3'b100;
  localparam logic [2:0] BR_BGE = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Radix-2 shift-add multiplier, one partial product per cycle for XLEN cycles.
// Only built when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  mul_state_e      state_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] acc_next;

  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  // The last step's sum is taken combinationally so the caller can register it at the done edge.
  assign busy    = ((state_reg == ST_IDLE) && start) || ((state_reg == ST_MUL) && (count_reg != LAST));
  assign done    = (state_reg == ST_MUL) && (count_reg == LAST);
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_MUL;
            count_reg  <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
          end
        end
        default: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          if (count_reg == LAST) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// RV64 execute stage: forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to build the iterative multiplier (ALUOp 11) that stalls via ex_busy.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IDEX_Branch,
  input  logic            IDEX_MemRead,
  input  logic            IDEX_MemWrite,
  input  logic            IDEX_MemtoReg,
  input  logic            IDEX_RegWrite,
  input  logic            IDEX_ALUSrc,
  input  logic [1:0]      IDEX_ALUOp,
  input  logic [3:0]      IDEX_Funct,
  input  logic [4:0]      IDEX_RS1,
  input  logic [4:0]      IDEX_RS2,
  input  logic [4:0]      IDEX_RD,
  input  logic [XLEN-1:0] IDEX_PC_Out,
  input  logic [XLEN-1:0] IDEX_ReadData1,
  input  logic [XLEN-1:0] IDEX_ReadData2,
  input  logic [XLEN-1:0] IDEX_Imm,
  input  logic            MEMWB_RegWrite,
  input  logic [4:0]      MEMWB_RD,
  input  logic [XLEN-1:0] MEMWB_WriteData,
  output logic            ex_busy,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            EXMEM_MemRead,
  output logic            EXMEM_MemWrite,
  output logic            EXMEM_MemtoReg,
  output logic            EXMEM_RegWrite,
  output logic [4:0]      EXMEM_RD,
  output logic [XLEN-1:0] EXMEM_ALUResult,
  output logic [XLEN-1:0] EXMEM_StoreData
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [5:0]      shamt;
  logic [XLEN-1:0] alu_result;
  logic            reg_write_eff;
  logic            branch_cond;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = IDEX_ReadData1;
    if (EXMEM_RegWrite && (EXMEM_RD != 5'd0) && (EXMEM_RD == IDEX_RS1))
      fwd_a = EXMEM_ALUResult;
    else if (MEMWB_RegWrite && (MEMWB_RD != 5'd0) && (MEMWB_RD == IDEX_RS1))
      fwd_a = MEMWB_WriteData;

    fwd_b = IDEX_ReadData2;
    if (EXMEM_RegWrite && (EXMEM_RD != 5'd0) && (EXMEM_RD == IDEX_RS2))
      fwd_b = EXMEM_ALUResult;
    else if (MEMWB_RegWrite && (MEMWB_RD != 5'd0) && (MEMWB_RD == IDEX_RS2))
      fwd_b = MEMWB_WriteData;
  end

  assign op_b  = IDEX_ALUSrc ? IDEX_Imm : fwd_b;
  assign shamt = op_b[5:0];

  always_comb begin
    alu_result    = '0;
    reg_write_eff = IDEX_RegWrite;
    branch_cond   = 1'b0;
    case (IDEX_ALUOp)
      ALUOP_ADD: alu_result = fwd_a + op_b;
      ALUOP_FUNCT: begin
        case (IDEX_Funct)
          FN_ADD:  alu_result = fwd_a + op_b;
          FN_SUB:  alu_result = fwd_a - op_b;
          FN_AND:  alu_result = fwd_a & op_b;
          FN_OR:   alu_result = fwd_a | op_b;
          FN_XOR:  alu_result = fwd_a ^ op_b;
          FN_SLL:  alu_result = fwd_a << shamt;
          FN_SRL:  alu_result = fwd_a >> shamt;
          FN_SRA:  alu_result = $signed(fwd_a) >>> shamt;
          default: alu_result = '0;
        endcase
      end
      ALUOP_BRANCH: begin
        reg_write_eff = 1'b0;
        case (IDEX_Funct[2:0])
          BR_BEQ:  branch_cond = (fwd_a == fwd_b);
          BR_BNE:  branch_cond = (fwd_a != fwd_b);
          BR_BLT:  branch_cond = ($signed(fwd_a) < $signed(fwd_b));
          BR_BGE:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
          default: branch_cond = 1'b0;
        endcase
      end
      default: begin
`ifndef EX_MUL_EN
        reg_write_eff = 1'b0;
`endif
      end
    endcase
  end

  assign branch_taken  = IDEX_Branch && (IDEX_ALUOp == ALUOP_BRANCH) && branch_cond;
  assign branch_target = IDEX_PC_Out + IDEX_Imm;

`ifdef EX_MUL_EN
  logic mul_start;
  assign mul_start = (IDEX_ALUOp == ALUOP_MUL) && (IDEX_Funct[2:0] == FN3_MUL);

  // The multiply stays in ID/EX until done, so its controls are still on the inputs then.
  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (fwd_a),
    .b       (fwd_b),
    .busy    (ex_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign ex_busy     = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset || ex_busy) begin
      EXMEM_MemRead   <= 1'b0;
      EXMEM_MemWrite  <= 1'b0;
      EXMEM_MemtoReg  <= 1'b0;
      EXMEM_RegWrite  <= 1'b0;
      EXMEM_RD        <= 5'd0;
      EXMEM_ALUResult <= '0;
      EXMEM_StoreData <= '0;
    end else begin
      EXMEM_MemRead   <= IDEX_MemRead;
      EXMEM_MemWrite  <= IDEX_MemWrite;
      EXMEM_MemtoReg  <= IDEX_MemtoReg;
      EXMEM_RegWrite  <= mul_done ? IDEX_RegWrite : reg_write_eff;
      EXMEM_RD        <= IDEX_RD;
      EXMEM_ALUResult <= mul_done ? mul_product : alu_result;
      EXMEM_StoreData <= fwd_b;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table, forwarding, branches, and the
// multiplier (or its disabled behaviour, depending on EX_MUL_EN).
module tb_ex_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegWrite, IDEX_ALUSrc;
  logic [1:0]      IDEX_ALUOp;
  logic [3:0]      IDEX_Funct;
  logic [4:0]      IDEX_RS1, IDEX_RS2, IDEX_RD;
  logic [XLEN-1:0] IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic            MEMWB_RegWrite;
  logic [4:0]      MEMWB_RD;
  logic [XLEN-1:0] MEMWB_WriteData;
  logic            ex_busy, branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite;
  logic [4:0]      EXMEM_RD;
  logic [XLEN-1:0] EXMEM_ALUResult, EXMEM_StoreData;

  int tests = 0;
  int fails = 0;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .IDEX_Branch(IDEX_Branch), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_ALUOp(IDEX_ALUOp), .IDEX_Funct(IDEX_Funct),
    .IDEX_RS1(IDEX_RS1), .IDEX_RS2(IDEX_RS2), .IDEX_RD(IDEX_RD),
    .IDEX_PC_Out(IDEX_PC_Out), .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2),
    .IDEX_Imm(IDEX_Imm),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_RD(MEMWB_RD), .MEMWB_WriteData(MEMWB_WriteData),
    .ex_busy(ex_busy), .branch_taken(branch_taken), .branch_target(branch_target),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite), .EXMEM_MemtoReg(EXMEM_MemtoReg),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_RD(EXMEM_RD),
    .EXMEM_ALUResult(EXMEM_ALUResult), .EXMEM_StoreData(EXMEM_StoreData)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   aluop;
    logic [3:0]   funct;
    logic         alusrc;
    logic [63:0]  rd1;
    logic [63:0]  rd2;
    logic [63:0]  imm;
    logic [63:0]  exp;
  } vec_t;

  typedef struct {
    string        name;
    logic         branch;
    logic [2:0]   f3;
    logic [63:0]  rd1;
    logic [63:0]  rd2;
    logic         exp_taken;
  } br_t;

  vec_t vecs[11];
  br_t  brs[6];

  function automatic vec_t mk(string n, logic [1:0] op, logic [3:0] fn, logic src,
                              logic [63:0] a, logic [63:0] b, logic [63:0] im, logic [63:0] e);
    vec_t v;
    v.name = n; v.aluop = op; v.funct = fn; v.alusrc = src;
    v.rd1 = a; v.rd2 = b; v.imm = im; v.exp = e;
    return v;
  endfunction

  function automatic br_t mkb(string n, logic br, logic [2:0] f, logic [63:0] a, logic [63:0] b, logic t);
    br_t v;
    v.name = n; v.branch = br; v.f3 = f; v.rd1 = a; v.rd2 = b; v.exp_taken = t;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    IDEX_Branch = 0; IDEX_MemRead = 0; IDEX_MemWrite = 0; IDEX_MemtoReg = 0;
    IDEX_RegWrite = 0; IDEX_ALUSrc = 0; IDEX_ALUOp = 2'b00; IDEX_Funct = 4'b0000;
    IDEX_RS1 = 0; IDEX_RS2 = 0; IDEX_RD = 0;
    IDEX_PC_Out = 0; IDEX_ReadData1 = 0; IDEX_ReadData2 = 0; IDEX_Imm = 0;
    MEMWB_RegWrite = 0; MEMWB_RD = 0; MEMWB_WriteData = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [3:0] fn, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] b);
    IDEX_ALUOp = op; IDEX_Funct = fn; IDEX_RS1 = rs1; IDEX_RS2 = rs2; IDEX_RD = rd;
    IDEX_ReadData1 = a; IDEX_ReadData2 = b; IDEX_RegWrite = 1; IDEX_ALUSrc = 0;
  endtask

  initial begin
    vecs[0]  = mk("sub",      2'b10, 4'b1000, 0, 64'd10, 64'd3, 64'd0, 64'd7);
    vecs[1]  = mk("add_imm",  2'b00, 4'b1000, 1, 64'd5, 64'd99, 64'h10, 64'h15);
    vecs[2]  = mk("and",      2'b10, 4'b0111, 0, 64'hF0F0, 64'hFF00, 64'd0, 64'hF000);
    vecs[3]  = mk("or",       2'b10, 4'b0110, 0, 64'hF0, 64'h0F, 64'd0, 64'hFF);
    vecs[4]  = mk("xor",      2'b10, 4'b0100, 0, 64'hFF, 64'h0F, 64'd0, 64'hF0);
    vecs[5]  = mk("sll63",    2'b10, 4'b0001, 0, 64'd1, 64'd63, 64'd0, 64'h8000_0000_0000_0000);
    vecs[6]  = mk("srl",      2'b10, 4'b0101, 0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'h0800_0000_0000_0000);
    vecs[7]  = mk("sra",      2'b10, 4'b1101, 0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'hF800_0000_0000_0000);
    vecs[8]  = mk("sll_mask", 2'b10, 4'b0001, 0, 64'd1, 64'h41, 64'd0, 64'd2);
    vecs[9]  = mk("bad_fn",   2'b10, 4'b0010, 0, 64'd7, 64'd9, 64'd0, 64'd0);
    vecs[10] = mk("sub_imm",  2'b10, 4'b1000, 1, 64'd0, 64'd5, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);

    brs[0] = mkb("beq_eq",   1, 3'b000, 64'h55, 64'h55, 1);
    brs[1] = mkb("bge_m1_0", 1, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    brs[2] = mkb("blt_m1_0", 1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    brs[3] = mkb("bne_eq",   1, 3'b001, 64'h7, 64'h7, 0);
    brs[4] = mkb("nobranch", 0, 3'b000, 64'h7, 64'h7, 0);
    brs[5] = mkb("f3_010",   1, 3'b010, 64'h7, 64'h7, 0);

    // Reset state
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, ex_busy}, 64'd0);
    check("rst_regwrite", {63'd0, EXMEM_RegWrite}, 64'd0);
    check("rst_memrd", {61'd0, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg}, 64'd0);
    check("rst_rd", {59'd0, EXMEM_RD}, 64'd0);
    check("rst_result", EXMEM_ALUResult, 64'd0);
    check("rst_store", EXMEM_StoreData, 64'd0);
    reset = 0;

    // ALU vector table; rs 1/2 never collide with the rd written by the previous vector
    for (int i = 0; i < 11; i++) begin
      set_op(vecs[i].aluop, vecs[i].funct, 5'd1, 5'd2, 5'(10 + i), vecs[i].rd1, vecs[i].rd2);
      IDEX_ALUSrc = vecs[i].alusrc;
      IDEX_Imm = vecs[i].imm;
      #1;
      if (i == 0) check("pre_result", EXMEM_ALUResult, 64'd0);
      tick();
      check({vecs[i].name, "_result"}, EXMEM_ALUResult, vecs[i].exp);
      check({vecs[i].name, "_rd"}, {59'd0, EXMEM_RD}, 64'(10 + i));
      check({vecs[i].name, "_store"}, EXMEM_StoreData, vecs[i].rd2);
      check({vecs[i].name, "_regwr"}, {63'd0, EXMEM_RegWrite}, 64'd1);
      $display("[TB] vec %s result=0x%h", vecs[i].name, EXMEM_ALUResult);
    end
    IDEX_ALUSrc = 0; IDEX_Imm = 0;

    // Forwarding: add x5=x1+x2, then and x6=x5&x5 with MEM/WB also writing x5
    set_op(2'b00, 4'b0000, 5'd1, 5'd2, 5'd5, 64'd4, 64'd6);
    tick();
    check("fwd_add", EXMEM_ALUResult, 64'd10);
    set_op(2'b10, 4'b0111, 5'd5, 5'd5, 5'd6, 64'hDEAD, 64'hDEAD);
    MEMWB_RegWrite = 1; MEMWB_RD = 5'd5; MEMWB_WriteData = 64'd99;
    tick();
    check("fwd_exmem_wins", EXMEM_ALUResult, 64'd10);
    check("fwd_exmem_store", EXMEM_StoreData, 64'd10);
    set_op(2'b00, 4'b0000, 5'd5, 5'd9, 5'd8, 64'hDEAD, 64'd1);
    tick();
    check("fwd_memwb", EXMEM_ALUResult, 64'd100);
    $display("[TB] forward sequence result=0x%h", EXMEM_ALUResult);
    // Writes to x0 must not forward from either stage
    set_op(2'b00, 4'b0000, 5'd1, 5'd2, 5'd0, 64'd4, 64'd6);
    IDEX_MemRead = 1; IDEX_MemtoReg = 1;
    MEMWB_RegWrite = 0;
    tick();
    check("rd0_result", EXMEM_ALUResult, 64'd10);
    check("ctl_memread", {62'd0, EXMEM_MemRead, EXMEM_MemtoReg}, 64'd3);
    IDEX_MemRead = 0; IDEX_MemtoReg = 0;
    set_op(2'b00, 4'b0000, 5'd0, 5'd0, 5'd7, 64'd0, 64'd0);
    MEMWB_RegWrite = 1; MEMWB_RD = 5'd0; MEMWB_WriteData = 64'd99;
    tick();
    check("x0_no_fwd", EXMEM_ALUResult, 64'd0);
    MEMWB_RegWrite = 0; MEMWB_RD = 0; MEMWB_WriteData = 0;

    // Branches resolve combinationally in the same cycle
    for (int i = 0; i < 6; i++) begin
      set_op(2'b01, {1'b0, brs[i].f3}, 5'd1, 5'd2, 5'd3, brs[i].rd1, brs[i].rd2);
      IDEX_Branch = brs[i].branch;
      IDEX_PC_Out = 64'h100; IDEX_Imm = 64'h20;
      #1;
      check({brs[i].name, "_taken"}, {63'd0, branch_taken}, {63'd0, brs[i].exp_taken});
      check({brs[i].name, "_target"}, branch_target, 64'h120);
      tick();
      check({brs[i].name, "_result"}, EXMEM_ALUResult, 64'd0);
      check({brs[i].name, "_regwr"}, {63'd0, EXMEM_RegWrite}, 64'd0);
      $display("[TB] branch %s taken=%0b", brs[i].name, brs[i].exp_taken);
    end
    IDEX_Branch = 0; IDEX_PC_Out = 0; IDEX_Imm = 0;

`ifdef EX_MUL_EN
    begin
      int busy_cycles;
      int bubbles;
      logic seen;
      // MUL 0xFFFF_FFFF x 3; inputs held while busy, as the upstream stall would
      set_op(2'b11, 4'b0000, 5'd1, 5'd2, 5'd12, 64'hFFFF_FFFF, 64'd3);
      #1;
      busy_cycles = 0;
      bubbles = 0;
      for (int i = 0; i < 200 && ex_busy; i++) begin
        busy_cycles++;
        tick();
        if (ex_busy && !EXMEM_RegWrite && EXMEM_ALUResult == 64'd0 && EXMEM_RD == 5'd0) bubbles++;
      end
      check("mul_busy_cycles", 64'(busy_cycles), 64'd64);
      check("mul_bubbles", 64'(bubbles), 64'd63);
      check("mul_last_busy", {63'd0, ex_busy}, 64'd0);
      tick();
      check("mul_result", EXMEM_ALUResult, 64'h2_FFFF_FFFD);
      check("mul_rd", {59'd0, EXMEM_RD}, 64'd12);
      check("mul_regwr", {63'd0, EXMEM_RegWrite}, 64'd1);
      $display("[TB] mul result=0x%h busy_cycles=%0d", EXMEM_ALUResult, busy_cycles);

      // Non-MUL funct under ALUOp 11 is a single-cycle zero
      set_op(2'b11, 4'b0001, 5'd1, 5'd2, 5'd13, 64'd7, 64'd3);
      #1;
      check("mul_fn_busy", {63'd0, ex_busy}, 64'd0);
      tick();
      check("mul_fn_result", EXMEM_ALUResult, 64'd0);

      // Reset at count 20 abandons the multiply
      set_op(2'b11, 4'b0000, 5'd1, 5'd2, 5'd14, 64'd5, 64'd7);
      tick();
      repeat (20) @(posedge clk);
      #1;
      check("abort_busy_before", {63'd0, ex_busy}, 64'd1);
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      check("abort_busy", {63'd0, ex_busy}, 64'd0);
      check("abort_regwr", {63'd0, EXMEM_RegWrite}, 64'd0);
      seen = 0;
      for (int i = 0; i < 70; i++) begin
        tick();
        if (EXMEM_ALUResult != 64'd0 || EXMEM_RegWrite || ex_busy) seen = 1;
      end
      check("abort_no_result", {63'd0, seen}, 64'd0);
      $display("[TB] mul abort checked");
    end
`else
    // Multiplier disabled: ALUOp 11 is a single-cycle no-write zero
    set_op(2'b11, 4'b0000, 5'd1, 5'd2, 5'd12, 64'hFFFF_FFFF, 64'd3);
    #1;
    check("nomul_busy", {63'd0, ex_busy}, 64'd0);
    tick();
    check("nomul_busy_after", {63'd0, ex_busy}, 64'd0);
    check("nomul_regwr", {63'd0, EXMEM_RegWrite}, 64'd0);
    check("nomul_result", EXMEM_ALUResult, 64'd0);
    check("nomul_rd", {59'd0, EXMEM_RD}, 64'd12);
    $display("[TB] mul disabled result=0x%h", EXMEM_ALUResult);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
